i2s_master_tx: RTL
==================

// Module: i2s_master_tx
// PURPOSE
// - I2S master transmitter: derives BCLK/LRCK from CLOCK, serializes stereo samples to the codec DAC input.
// - Counterpart of the slave-mode DAC serializer, for codec-as-slave configurations.
// - Sample source pushes L/R pairs via valid/ready into a 1-entry holding register.
// PARAMETERS
// - CLK_DIV    16  CLOCK cycles per BCLK half-period (>=1); BCLK = f(CLOCK)/(2*CLK_DIV)
// - SAMPLE_W   16  bits per channel sample (1..SLOT_BITS-1)
// - SLOT_BITS  32  BCLK periods per channel slot; frame = 2*SLOT_BITS BCLKs
// PORTS
// - CLOCK        in   1         system clock, all logic on posedge
// - RESET        in   1         asynchronous, active-high reset
// - DIN_L        in   SAMPLE_W  left sample, two's complement
// - DIN_R        in   SAMPLE_W  right sample
// - DIN_VALID    in   1         DIN_L/DIN_R valid
// - DIN_READY    out  1         holding register empty; transfer when VALID&&READY
// - AUD_BCLK     out  1         bit clock
// - AUD_DACLRCK  out  1         word select: 0 = left slot, 1 = right slot
// - AUD_DACDAT   out  1         serial data, MSB first
// - FRAME_START  out  1         1-cycle pulse when a new frame is loaded
// - UNDERRUN     out  1         1-cycle pulse when a frame loads with holding register empty
// BEHAVIOUR
// - Reset values: BCLK=0, DACLRCK=1, DACDAT=0, DIN_READY=1, FRAME_START=0, UNDERRUN=0.
// - Internal reset: divider=0, bit counter=2*SLOT_BITS-1, holding empty, shift regs=0.
// - Divider counts 0..CLK_DIV-1; at terminal count BCLK toggles.
// - BCLK rise: no data change (codec samples here).
// - BCLK fall (registered 1-to-0 toggle):
//   - bit counter b increments mod 2*SLOT_BITS.
//   - DACLRCK = (b >= SLOT_BITS); p = b mod SLOT_BITS.
//   - DACDAT = 0 at p=0 (I2S one-bit delay); sample bit [SAMPLE_W-p] for p=1..SAMPLE_W; 0 for p>SAMPLE_W.
// - Frame load, on the BCLK fall where b becomes 0:
//   - holding full: copy to L/R shift regs, mark empty, pulse FRAME_START.
//   - holding empty: load zeros, pulse FRAME_START and UNDERRUN.
// - First frame begins 2*CLK_DIV cycles after reset release; reset-time empty holding gives UNDERRUN on frame 0.
// - Handshake:
//   - DIN_READY is registered = !holding_full.
//   - accept on VALID&&READY, capture DIN_L/DIN_R, READY low next cycle.
// - Accept and frame load in the same cycle: load sees pre-accept state (underrun); accepted pair plays next frame.
// - Load while full: READY cannot be high, no conflict; READY returns 1 the cycle after load.
// - Max sustained rate: one pair per frame; source stalls otherwise, no data loss.
// - Mid-operation RESET: all outputs return to reset values immediately; held sample discarded.
// CONFIGURATION
// - Macro I2S_UNDERRUN_REPEAT_EN.
// - Defined: underrun reloads the previous frame's L/R pair (zeros if none since reset). UNDERRUN still pulses.
// - Undefined: underrun transmits zeros.
// TESTING (CLK_DIV=2, SAMPLE_W=16, SLOT_BITS=32)
// - Reset 5 cycles, release -> outputs at reset values; BCLK period 4 CLOCKs; DACLRCK period 256 CLOCKs, low half first.
// - Push L=16'hA5F0, R=16'h0001 before frame 1 -> left slot bits p0..31 = 0,1010010111110000,15x0; right slot = 0,0000000000000001,15x0.
// - Load frame with no push -> UNDERRUN pulses once; DACDAT all 0 for 64 BCLKs (REPEAT_EN: previous pair repeats).
// - Hold DIN_VALID=1 continuously -> exactly one accept per frame; READY low ~256 CLOCKs; pairs play in order, none lost.
// - Push in the same cycle as frame load -> UNDERRUN that frame; pair plays in the next frame.
// - Assert RESET mid-right-slot -> BCLK=0, DACLRCK=1, DACDAT=0, READY=1 immediately; clean frame restarts after release.

Source files
------------

// File: rtl/i2s_master_tx.sv
// i2s_master_tx - I2S master transmitter for codec-as-slave setups.
//
// Derives AUD_BCLK and AUD_DACLRCK from CLOCK and shifts stereo samples out
// on AUD_DACDAT, MSB first, with the standard one-BCLK delay after each LRCK
// edge. Data changes only on BCLK falling edges so the codec can sample on
// the rising edge. A one-entry holding register takes an L/R pair from the
// source. That pair is copied into the shift registers at the start of each
// frame.
//
// Ports:
//   CLOCK        system clock, all logic on posedge
//   RESET        asynchronous active-high reset
//   DIN_L/DIN_R  left/right sample (two's complement, SAMPLE_W bits)
//   DIN_VALID    sample pair valid
//   DIN_READY    holding register empty; transfer on DIN_VALID && DIN_READY
//   AUD_BCLK     bit clock, CLOCK / (2*CLK_DIV)
//   AUD_DACLRCK  word select: 0 = left slot, 1 = right slot
//   AUD_DACDAT   serial data
//   FRAME_START  one-cycle pulse when a frame is loaded
//   UNDERRUN     one-cycle pulse when a frame loads with the holding register empty
//
// Build option:
//   I2S_UNDERRUN_REPEAT_EN - when defined, an underrun replays the last pair
//   that actually came from the holding register (zeros if there has been
//   none since reset). When undefined, an underrun sends silence.

module i2s_master_tx #(
    parameter int CLK_DIV   = 16,
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [SAMPLE_W-1:0] DIN_L,
    input  logic [SAMPLE_W-1:0] DIN_R,
    input  logic                DIN_VALID,
    output logic                DIN_READY,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                FRAME_START,
    output logic                UNDERRUN
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int POS_W      = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_BITS);
    localparam logic [POS_W-1:0] LAST_DATA = POS_W'(SAMPLE_W);

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] shift_l, shift_r;
    logic [SAMPLE_W-1:0] load_l, load_r;

    logic                div_tc;
    logic                bclk_fall;
    logic [BIT_W-1:0]    bit_nxt;
    logic                slot_nxt;
    logic [POS_W-1:0]    pos_nxt;
    logic                data_pos;
    logic                frame_load;
    logic                accept;

    assign div_tc     = (div_cnt == DIV_LAST);
    assign bclk_fall  = div_tc && AUD_BCLK;
    assign bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign slot_nxt   = (bit_nxt >= SLOT_SIZE);
    assign pos_nxt    = slot_nxt ? POS_W'(bit_nxt - SLOT_SIZE) : POS_W'(bit_nxt);
    // Position 0 of each slot is the I2S one-bit delay. Sample bits follow it.
    assign data_pos   = (pos_nxt != '0) && (pos_nxt <= LAST_DATA);
    assign frame_load = bclk_fall && (bit_nxt == '0);

    assign DIN_READY  = !hold_full;
    assign accept     = DIN_VALID && !hold_full;

`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [SAMPLE_W-1:0] prev_l, prev_r;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            prev_l <= '0;
            prev_r <= '0;
        end else if (frame_load && hold_full) begin
            prev_l <= hold_l;
            prev_r <= hold_r;
        end
    end

    assign load_l = hold_full ? hold_l : prev_l;
    assign load_r = hold_full ? hold_r : prev_r;
`else
    assign load_l = hold_full ? hold_l : '0;
    assign load_r = hold_full ? hold_r : '0;
`endif

    // The frame load samples hold_full before this cycle's accept. A pair
    // accepted in the same cycle as a load therefore plays in the next frame.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= DIN_L;
            hold_r    <= DIN_R;
        end else if (frame_load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b1;
            AUD_DACDAT  <= 1'b0;
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
            shift_l     <= '0;
            shift_r     <= '0;
        end else begin
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
            div_cnt     <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                AUD_BCLK <= !AUD_BCLK;
            end
            if (bclk_fall) begin
                bit_cnt     <= bit_nxt;
                AUD_DACLRCK <= slot_nxt;
                if (frame_load) begin
                    shift_l     <= load_l;
                    shift_r     <= load_r;
                    FRAME_START <= 1'b1;
                    UNDERRUN    <= !hold_full;
                    AUD_DACDAT  <= 1'b0;
                end else if (data_pos) begin
                    if (slot_nxt) begin
                        AUD_DACDAT <= shift_r[SAMPLE_W-1];
                        shift_r    <= shift_r << 1;
                    end else begin
                        AUD_DACDAT <= shift_l[SAMPLE_W-1];
                        shift_l    <= shift_l << 1;
                    end
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule
